// File: rtl/ota_sd_stim.sv
// First-order sigma-delta stimulus generator for an OTA input: static code,
// sawtooth ramp or triangle sweep, with load handshake and sweep-boundary sync.
module ota_sd_stim (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] code_in,
    input  logic       load,
    input  logic [1:0] mode,
    input  logic [3:0] ramp_div,
    output logic       dac_out,
    output logic [7:0] cur_code,
    output logic       load_ack,
    output logic       sync
);

    typedef enum logic [1:0] {
        MODE_STATIC     = 2'b00,
        MODE_RAMP       = 2'b01,
        MODE_TRI        = 2'b10,
        MODE_STATIC_ALT = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [7:0]  acc;
    logic [11:0] presc;
    mode_e       mode_q;
    dir_e        dir;

    logic [8:0]  sum;
    logic [11:0] presc_max;
    logic        sweeping;
    logic        tick;
    logic        tri_entry;
    logic [7:0]  step_code;
    dir_e        step_dir;
    logic        step_sync;

    assign sum       = {1'b0, acc} + {1'b0, cur_code};
    assign presc_max = {ramp_div, 8'hFF};
    assign sweeping  = (mode_q == MODE_RAMP) || (mode_q == MODE_TRI);
    // >= keeps ticking sane if ramp_div shrinks while the prescaler is above the new limit
    assign tick      = sweeping && (presc >= presc_max);
    assign tri_entry = (mode_e'(mode) == MODE_TRI) && (mode_q != MODE_TRI);

    // Next code, direction and sync for a ramp tick.
    always_comb begin
        step_code = cur_code;
        step_dir  = dir;
        step_sync = 1'b0;
        if (mode_q == MODE_RAMP) begin
            step_code = cur_code + 8'd1;
            step_sync = (cur_code == 8'hFF);
        end else if (mode_q == MODE_TRI) begin
            if (dir == DIR_UP)
                step_code = (cur_code == 8'hFF) ? 8'hFE : cur_code + 8'd1;
            else
                step_code = (cur_code == 8'h00) ? 8'h01 : cur_code - 8'd1;
            if (step_code == 8'hFF) begin
                step_dir = DIR_DOWN;
            end else if (step_code == 8'h00) begin
                step_dir  = DIR_UP;
                step_sync = 1'b1;
            end
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= 8'd0;
            presc    <= 12'd0;
            cur_code <= 8'd0;
            dir      <= DIR_UP;
            mode_q   <= MODE_STATIC;
            dac_out  <= 1'b0;
            load_ack <= 1'b0;
            sync     <= 1'b0;
        end else if (ena) begin
            acc      <= sum[7:0];
            dac_out  <= sum[8];
            mode_q   <= mode_e'(mode);
            load_ack <= load;
            sync     <= 1'b0;

            if (load || tri_entry || !sweeping || tick)
                presc <= 12'd0;
            else
                presc <= presc + 12'd1;

            // A load wins over a coincident tick; the tick is simply dropped.
            if (load) begin
                cur_code <= code_in;
                acc      <= 8'd0;
            end else if (tick) begin
                cur_code <= step_code;
                dir      <= step_dir;
                sync     <= step_sync;
            end

            if (tri_entry)
                dir <= DIR_UP;
        end else begin
            dac_out  <= 1'b0;
            load_ack <= 1'b0;
            sync     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ota_sd_stim.sv
// Directed self-checking bench for ota_sd_stim: static duty, extremes, ramp,
// triangle, load/tick collision, enable freeze and asynchronous reset mid-sweep.
module tb_ota_sd_stim;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] code_in;
    logic       load;
    logic [1:0] mode;
    logic [3:0] ramp_div;
    logic       dac_out;
    logic [7:0] cur_code;
    logic       load_ack;
    logic       sync;

    int checks = 0;
    int errors = 0;

    ota_sd_stim dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .code_in  (code_in),
        .load     (load),
        .mode     (mode),
        .ramp_div (ramp_div),
        .dac_out  (dac_out),
        .cur_code (cur_code),
        .load_ack (load_ack),
        .sync     (sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the falling edge after the capturing rising edge.
    task automatic do_load(input logic [7:0] code);
        code_in = code;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(negedge clk);
            ones += int'(dac_out);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({dac_out, cur_code, load_ack, sync} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got dac=%b code=%0d ack=%b sync=%b, want all 0",
                     dac_out, cur_code, load_ack, sync);
        end
    endtask

    task automatic test_static;
        int ones;
        mode = 2'b00;
        cycles(2);
        do_load(8'd64);
        checks++;
        if (load_ack !== 1'b1 || cur_code !== 8'd64) begin
            errors++;
            $display("FAIL static_load: got ack=%b code=%0d, want ack=1 code=64", load_ack, cur_code);
        end
        count_ones(256, ones);
        checks++;
        if (ones != 64) begin
            errors++;
            $display("FAIL static_duty64: got %0d ones, want 64", ones);
        end
    endtask

    task automatic test_ack_width;
        int highs = 0;
        do_load(8'd64);
        repeat (4) begin
            @(negedge clk);
            highs += int'(load_ack);
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("FAIL ack_one_cycle: got %0d extra high cycles, want 0", highs);
        end
    endtask

    task automatic test_extremes;
        int ones;
        do_load(8'd0);
        count_ones(512, ones);
        checks++;
        if (ones != 0) begin
            errors++;
            $display("FAIL code0_zero: got %0d ones in 512, want 0", ones);
        end
        do_load(8'd255);
        count_ones(256, ones);
        checks++;
        if (ones != 255) begin
            errors++;
            $display("FAIL code255_duty: got %0d ones, want 255", ones);
        end
    endtask

    task automatic test_ramp;
        int syncs = 0;
        mode     = 2'b01;
        ramp_div = 4'd0;
        cycles(2);
        do_load(8'd254);
        cycles(255);
        checks++;
        if (cur_code !== 8'd254) begin
            errors++;
            $display("FAIL ramp_hold255: got %0d, want 254", cur_code);
        end
        cycles(1);
        checks++;
        if (cur_code !== 8'd255) begin
            errors++;
            $display("FAIL ramp_step256: got %0d, want 255", cur_code);
        end
        repeat (256) begin
            @(negedge clk);
            syncs += int'(sync);
        end
        checks++;
        if (cur_code !== 8'd0 || sync !== 1'b1 || syncs != 1) begin
            errors++;
            $display("FAIL ramp_wrap: got code=%0d sync=%b pulses=%0d, want 0 1 1", cur_code, sync, syncs);
        end
    endtask

    task automatic test_triangle;
        mode     = 2'b10;
        ramp_div = 4'd0;
        cycles(3);
        do_load(8'd254);
        cycles(256);
        checks++;
        if (cur_code !== 8'd255) begin
            errors++;
            $display("FAIL tri_up255: got %0d, want 255", cur_code);
        end
        cycles(256);
        checks++;
        if (cur_code !== 8'd254) begin
            errors++;
            $display("FAIL tri_down254: got %0d, want 254", cur_code);
        end
        cycles(256);
        checks++;
        if (cur_code !== 8'd253) begin
            errors++;
            $display("FAIL tri_down253: got %0d, want 253", cur_code);
        end
        do_load(8'd1);
        cycles(256);
        checks++;
        if (cur_code !== 8'd0 || sync !== 1'b1) begin
            errors++;
            $display("FAIL tri_bottom: got code=%0d sync=%b, want 0 1", cur_code, sync);
        end
        cycles(256);
        checks++;
        if (cur_code !== 8'd1 || sync !== 1'b0) begin
            errors++;
            $display("FAIL tri_rebound: got code=%0d sync=%b, want 1 0", cur_code, sync);
        end
    endtask

    task automatic test_collision;
        mode     = 2'b01;
        ramp_div = 4'd0;
        cycles(2);
        do_load(8'd10);
        cycles(255);
        do_load(8'd100);
        checks++;
        if (cur_code !== 8'd100 || load_ack !== 1'b1) begin
            errors++;
            $display("FAIL collide_load: got code=%0d ack=%b, want 100 1", cur_code, load_ack);
        end
        cycles(255);
        checks++;
        if (cur_code !== 8'd100) begin
            errors++;
            $display("FAIL collide_presc_clear: got %0d, want 100", cur_code);
        end
        cycles(1);
        checks++;
        if (cur_code !== 8'd101) begin
            errors++;
            $display("FAIL collide_next_tick: got %0d, want 101", cur_code);
        end
    endtask

    task automatic test_enable;
        int ones_a;
        int ones_b;
        int frozen_ones = 0;
        int acks = 0;
        int bad_code = 0;
        mode = 2'b00;
        cycles(2);
        do_load(8'd64);
        count_ones(100, ones_a);
        ena = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 40) begin
                code_in = 8'd200;
                load    = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
            frozen_ones += int'(dac_out);
            acks        += int'(load_ack);
            if (cur_code !== 8'd64) bad_code++;
        end
        checks++;
        if (frozen_ones != 0) begin
            errors++;
            $display("FAIL freeze_dac: got %0d ones while disabled, want 0", frozen_ones);
        end
        checks++;
        if (acks != 0 || bad_code != 0) begin
            errors++;
            $display("FAIL freeze_load_ignored: got %0d acks %0d bad codes, want 0 0", acks, bad_code);
        end
        ena = 1'b1;
        count_ones(156, ones_b);
        checks++;
        if (ones_a + ones_b != 64) begin
            errors++;
            $display("FAIL freeze_resume_count: got %0d ones, want 64", ones_a + ones_b);
        end
    endtask

    task automatic test_reset_mid;
        int syncs = 0;
        mode     = 2'b10;
        ramp_div = 4'd0;
        cycles(3);
        do_load(8'd100);
        cycles(300);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dac_out, cur_code, load_ack, sync} !== 11'd0) begin
            errors++;
            $display("FAIL reset_async: got dac=%b code=%0d ack=%b sync=%b, want all 0",
                     dac_out, cur_code, load_ack, sync);
        end
        cycles(2);
        rst = 1'b0;
        repeat (256) begin
            @(negedge clk);
            syncs += int'(sync);
        end
        checks++;
        if (cur_code !== 8'd0) begin
            errors++;
            $display("FAIL reset_restart_hold: got %0d, want 0", cur_code);
        end
        @(negedge clk);
        syncs += int'(sync);
        checks++;
        if (cur_code !== 8'd1 || syncs != 0) begin
            errors++;
            $display("FAIL reset_restart_up: got code=%0d syncs=%0d, want 1 0", cur_code, syncs);
        end
    endtask

    initial begin
        rst      = 1'b1;
        ena      = 1'b0;
        code_in  = 8'd0;
        load     = 1'b0;
        mode     = 2'b00;
        ramp_div = 4'd0;
        #1;
        test_reset();
        cycles(2);
        rst = 1'b0;
        ena = 1'b1;
        test_static();
        test_ack_width();
        test_extremes();
        test_ramp();
        test_triangle();
        test_collision();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ota_sd_stim.md
OTA_SD_STIM -- requirements
Module: ota_sd_stim

Interface
REQ-001 SHALL have port: clk  input  1  single clock, rising edge active.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: ena  input  1  run enable; low freezes all state.
REQ-004 SHALL have port: code_in  input  8  requested DAC code (unsigned).
REQ-005 SHALL have port: load  input  1  one-cycle strobe; captures code_in.
REQ-006 SHALL have port: mode  input  2  00 static, 01 ramp-up, 10 triangle, 11 treated as static.
REQ-007 SHALL have port: ramp_div  input  4  ramp step period selector.
REQ-008 SHALL have port: dac_out  output  1  registered first-order sigma-delta bitstream, feeding the OTA analog input through an external RC filter.
REQ-009 SHALL have port: cur_code  output  8  code currently being modulated.
REQ-010 SHALL have port: load_ack  output  1  one-cycle pulse confirming a load.
REQ-011 SHALL have port: sync  output  1  one-cycle pulse marking a sweep boundary.

Function
REQ-012 SHALL keep an 8-bit accumulator; when ena=1, each cycle {carry,acc} <= acc + cur_code and dac_out <= carry.
REQ-013 SHALL produce exactly cur_code ones in every 256 consecutive enabled cycles while cur_code is constant and the accumulator starts at 0.
REQ-014 SHALL make code 0 yield a constant dac_out=0 and code 255 yield 255 ones per 256 cycles.
REQ-015 SHALL, on load=1 with ena=1, set cur_code <= code_in, clear the accumulator, clear the prescaler, and pulse load_ack on the following cycle.
REQ-016 SHALL ignore load while ena=0; load_ack SHALL NOT pulse.
REQ-017 SHALL keep a 12-bit prescaler counting 0 .. (ramp_div+1)*256-1 in modes 01/10; a ramp tick SHALL occur on the cycle the prescaler wraps to 0.
REQ-018 SHALL hold the prescaler at 0 in static modes (00, 11).
REQ-019 SHALL, in mode 01, increment cur_code by 1 on each tick; 255 SHALL wrap to 0, with sync pulsing the cycle cur_code becomes 0.
REQ-020 SHALL, in mode 10, step cur_code by +1 (direction up) or -1 (direction down) on each tick; reaching 255 SHALL set direction down; reaching 0 SHALL set direction up and pulse sync.
REQ-021 SHALL give load priority over a simultaneous ramp tick; the tick is discarded.
REQ-022 SHALL apply a mode change on the next cycle without altering cur_code; entering mode 10 SHALL force direction up and clear the prescaler.
REQ-023 SHALL, while ena=0, hold accumulator, prescaler, cur_code and direction, force dac_out=0, and hold load_ack and sync at 0.
REQ-024 SHALL NOT clear the accumulator on ramp ticks; modulation is continuous across code steps.

Reset
REQ-025 SHALL, while rst=1, immediately force dac_out=0, cur_code=0, load_ack=0, sync=0, accumulator=0, prescaler=0, direction=up, independent of clk.
REQ-026 SHALL resume on the first rising clk edge after rst falls, with mode 00 behaviour equal to static code 0 until a load.
REQ-027 SHALL abandon any in-progress sweep on reset assertion; no sync pulse SHALL be emitted due to reset.

Verification
REQ-028 Static: mode=00, load code 64, count dac_out over 256 cycles -> exactly 64 ones; load_ack high exactly one cycle after load.
REQ-029 Extremes: load 0 -> 512 cycles all zero; load 255 -> exactly 255 ones in 256 cycles.
REQ-030 Ramp: mode=01, ramp_div=0, load 254 -> cur_code=255 after 256 cycles, 0 after 512 with one sync pulse.
REQ-031 Triangle: mode=10, ramp_div=0, load 254 -> 255, then 254, 253 at 256-cycle steps; from load 1 -> 0 with sync, then 1.
REQ-032 Collision/enable: load asserted on a tick cycle -> cur_code=code_in, no step; ena=0 for 100 cycles -> dac_out=0, cur_code and count resume unchanged.
REQ-033 Reset mid-sweep: assert rst between clock edges during mode 10 -> all outputs 0 immediately; after release, triangle restarts upward from 0.
